// File: rtl/cle_pkg.sv
// Shared CLE definitions: label-map geometry, SRAM port identities and the
// small structs used by the label SRAM arbiter.
package cle_pkg;

    localparam int CLE_IMG_W    = 32;
    localparam int CLE_ADDR_W   = $clog2(CLE_IMG_W * CLE_IMG_W);
    localparam int CLE_DATA_W   = 8;
    localparam int CLE_LOCK_MAX = 16;

    // Requester identities on the label SRAM
    typedef enum logic {
        CLE_P_LABEL   = 1'b0,  // pass-1 labeler
        CLE_P_RELABEL = 1'b1   // pass-2 relabeler / equivalence resolver
    } cle_port_e;

    // Current burst (lock) owner of the SRAM
    typedef struct packed {
        logic      valid;
        cle_port_e id;
    } cle_owner_t;

    // Tag carried alongside a read through the SRAM latency
    typedef struct packed {
        logic      valid;
        cle_port_e id;
    } cle_rtag_t;

    // One-hot grant/valid vector for a port id
    function automatic logic [1:0] cle_port_onehot(cle_port_e p);
        return (p == CLE_P_RELABEL) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cle_rr_arb2.sv
// Two-way round-robin arbiter with bounded lock (burst) support.
// Pure arbitration: grant is combinational from req/lock and the registered
// pointer/owner/count state; no datapath here.
module cle_rr_arb2
    import cle_pkg::*;
#(
    parameter int LOCK_MAX = CLE_LOCK_MAX
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output cle_owner_t owner
);

    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rr_ptr_q, rr_ptr_d;      // port that wins the next plain contention
    cle_owner_t       owner_q, owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;  // grants given to the current owner

    logic      contended;
    logic      owner_holds;    // owner still requesting with lock asserted
    logic      owner_expired;  // owner has used up its burst allowance
    logic      gnt_any;
    cle_port_e gnt_id;

    // Grant decision for this cycle
    always_comb begin
        contended     = req[0] & req[1];
        owner_holds   = owner_q.valid & req[owner_q.id] & lock[owner_q.id];
        owner_expired = owner_holds & (lock_cnt_q >= CNT_MAX);
        gnt_any       = 1'b0;
        gnt_id        = CLE_P_LABEL;
        if (!reset) begin
            if (contended) begin
                gnt_any = 1'b1;
                if (owner_expired) begin
                    gnt_id = cle_port_e'(~owner_q.id);
                end else if (owner_holds) begin
                    gnt_id = owner_q.id;
                end else begin
                    gnt_id = cle_port_e'(rr_ptr_q);
                end
            end else if (req[1]) begin
                gnt_any = 1'b1;
                gnt_id  = CLE_P_RELABEL;
            end else if (req[0]) begin
                gnt_any = 1'b1;
                gnt_id  = CLE_P_LABEL;
            end
        end
        gnt = gnt_any ? cle_port_onehot(gnt_id) : 2'b00;
    end

    // Pointer, owner and burst counter updates
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        // Owner releases the lock by dropping req or lock
        if (!owner_holds) begin
            owner_d.valid = 1'b0;
            lock_cnt_d    = '0;
        end
        // Forced release: the other port takes this cycle, allowance restarts
        if (contended && owner_expired) begin
            lock_cnt_d = '0;
        end
        if (gnt_any) begin
            rr_ptr_d = ~gnt_id;
            if (lock[gnt_id]) begin
                if (owner_holds && (owner_q.id == gnt_id)) begin
                    if (lock_cnt_d < CNT_MAX) begin
                        lock_cnt_d = lock_cnt_d + CNT_ONE;
                    end
                end else begin
                    owner_d.valid = 1'b1;
                    owner_d.id    = gnt_id;
                    lock_cnt_d    = CNT_ONE;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= 1'b0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign owner = owner_q;

endmodule

// File: rtl/cle_sram_arb.sv
// Label SRAM arbiter/sequencer: two requesters share one single-port SRAM.
// Handshake: a port holds req (with we/addr/wdata) until it sees gnt in the
// same cycle; gnt is the accept and the access is committed at that edge.
// A read returns one rvalid[i] pulse two cycles after its grant with rdata;
// writes return nothing. Accesses complete strictly in grant order.
module cle_sram_arb
    import cle_pkg::*;
#(
    parameter int ADDR_W   = CLE_ADDR_W,
    parameter int DATA_W   = CLE_DATA_W,
    parameter int LOCK_MAX = CLE_LOCK_MAX
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        lock,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    input  logic [DATA_W-1:0] sram_q,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_wen
);

    cle_owner_t        arb_owner;

    logic              gnt_any;
    cle_port_e         sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [DATA_W-1:0] sram_d_q, sram_d_d;
    logic              sram_wen_q, sram_wen_d;
    cle_rtag_t         tag1_q, tag1_d;      // read on the pins this cycle
    logic [1:0]        rvalid_q, rvalid_d;  // read data returning this cycle
    logic              acc1_q, acc1_d;      // grant happened one cycle ago
    logic              acc2_q, acc2_d;      // grant happened two cycles ago

    cle_rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .gnt   (gnt),
        .owner (arb_owner)
    );

    // Select the granted port's request fields
    always_comb begin
        gnt_any   = |gnt;
        sel_id    = gnt[1] ? CLE_P_RELABEL : CLE_P_LABEL;
        sel_addr  = gnt[1] ? addr1  : addr0;
        sel_wdata = gnt[1] ? wdata1 : wdata0;
        sel_we    = gnt[1] ? we[1]  : we[0];
    end

    // Next SRAM pin values, read tag pipe and in-flight tracking
    always_comb begin
        sram_a_d   = sram_a_q;
        sram_d_d   = sram_d_q;
        sram_wen_d = 1'b1;
        tag1_d     = '0;
        rvalid_d   = 2'b00;
        acc1_d     = gnt_any;
        acc2_d     = acc1_q;
        if (gnt_any) begin
            sram_a_d     = sel_addr;
            sram_wen_d   = ~sel_we;
            tag1_d.valid = ~sel_we;
            tag1_d.id    = sel_id;
            // Write data only moves for writes so the bus stays quiet on reads
            if (sel_we) begin
                sram_d_d = sel_wdata;
            end
        end
        if (tag1_q.valid) begin
            rvalid_d = cle_port_onehot(tag1_q.id);
        end
    end

    // Pin registers and pipeline state; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_a_q   <= '0;
            sram_d_q   <= '0;
            sram_wen_q <= 1'b1;
            tag1_q     <= '0;
            rvalid_q   <= 2'b00;
            acc1_q     <= 1'b0;
            acc2_q     <= 1'b0;
        end else begin
            sram_a_q   <= sram_a_d;
            sram_d_q   <= sram_d_d;
            sram_wen_q <= sram_wen_d;
            tag1_q     <= tag1_d;
            rvalid_q   <= rvalid_d;
            acc1_q     <= acc1_d;
            acc2_q     <= acc2_d;
        end
    end

    assign sram_a   = sram_a_q;
    assign sram_d   = sram_d_q;
    assign sram_wen = sram_wen_q;
    assign rvalid   = rvalid_q;
    assign rdata    = sram_q;
    // Any grant in the last two cycles covers every pending read response
    assign busy     = acc1_q | acc2_q;

    // At most one port is granted per cycle
    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));

    // A lock owner requesting alone is never held off
    a_owner_alone: assert property (@(posedge clk) disable iff (reset)
        (arb_owner.valid && (req == cle_port_onehot(arb_owner.id))) |-> (gnt == req));

endmodule

// File: tb/tb_cle_sram_arb.sv
// Bench for the label SRAM arbiter: behavioural SRAM, directed sequences,
// and a read scoreboard fed at grant time and drained on rvalid.
module tb_cle_sram_arb;

    localparam int LOCK_MAX = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req, we, lock;
    logic [9:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] sram_q;
    logic [9:0] sram_a;
    logic [7:0] sram_d;
    logic       sram_wen;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];   // {port, data} of each granted read, in grant order
    logic [8:0] exp_e;
    logic [7:0] sram_mem[1024];
    bit         sram_init = 1'b0;
    logic [7:0] ref_mem[1024];
    bit         ref_init = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    cle_sram_arb #(
        .ADDR_W   (10),
        .DATA_W   (8),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .lock     (lock),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .busy     (busy),
        .sram_q   (sram_q),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_wen (sram_wen)
    );

    function automatic logic [7:0] pat(int k);
        return 8'(k * 37 + 11);
    endfunction

    // Single-port synchronous SRAM, preloaded on the first edge
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int k = 0; k < 1024; k++) sram_mem[k] <= pat(k);
            sram_init <= 1'b1;
        end else if (!sram_wen) begin
            sram_mem[sram_a] <= sram_d;
        end
        sram_q <= sram_mem[sram_a];
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 2'b00; we = 2'b00; lock = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic apply_reset(int n);
        reset = 1'b1;
        exp_q.delete();
        repeat (n) next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- issue side: model update and expected push ----------------
    always @(negedge clk) begin
        if (!ref_init) begin
            for (int k = 0; k < 1024; k++) ref_mem[k] = pat(k);
            ref_init = 1'b1;
        end
        if (!reset && gnt != 2'b00) begin
            check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
            if (gnt[1]) begin
                if (we[1]) ref_mem[addr1] = wdata1;
                else       exp_q.push_back({1'b1, ref_mem[addr1]});
            end else begin
                if (we[0]) ref_mem[addr0] = wdata0;
                else       exp_q.push_back({1'b0, ref_mem[addr0]});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && rvalid != 2'b00) begin
            check("rvalid_onehot", 32'($onehot(rvalid)), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: got rvalid=%b expected no outstanding read at %0t",
                         rvalid, $time);
            end else begin
                exp_e = exp_q.pop_front();
                check("rd_port", 32'(rvalid[1]), 32'(exp_e[8]));
                check("rdata", 32'(rdata), 32'(exp_e[7:0]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got no end of test expected finish before 1ms");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequences ----------------
    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset held 3 cycles, then idle
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            check("rst_wen", 32'(sram_wen), 32'd1);
            check("rst_rvalid", 32'(rvalid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        check("rst_sram_a", 32'(sram_a), 32'd0);
        check("rst_sram_d", 32'(sram_d), 32'd0);
        next_cycle();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_wen", 32'(sram_wen), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            next_cycle();
        end

        // P0 write 0x021 <- 0x05, then P0 read 0x021
        req = 2'b01; we = 2'b01; addr0 = 10'h021; wdata0 = 8'h05;
        @(negedge clk);
        check("t2_gnt_wr", 32'(gnt), 32'b01);
        next_cycle();
        req = 2'b01; we = 2'b00; addr0 = 10'h021;
        @(negedge clk);
        check("t2_gnt_rd", 32'(gnt), 32'b01);
        check("t2_wen_low", 32'(sram_wen), 32'd0);
        check("t2_sram_a", 32'(sram_a), 32'h021);
        check("t2_sram_d", 32'(sram_d), 32'h05);
        check("t2_busy", 32'(busy), 32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t2_rd_wen", 32'(sram_wen), 32'd1);
        check("t2_rd_a", 32'(sram_a), 32'h021);
        check("t2_no_early_rvalid", 32'(rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("t2_rvalid", 32'(rvalid), 32'b01);
        check("t2_rdata", 32'(rdata), 32'h05);
        next_cycle();
        @(negedge clk);
        check("t2_busy_drain", 32'(busy), 32'd0);
        check("t2_wen_idle", 32'(sram_wen), 32'd1);
        next_cycle();

        // Both ports read every cycle, no lock: strict alternation from P0
        apply_reset(2);
        for (int i = 0; i < 8; i++) begin
            req = 2'b11; we = 2'b00; lock = 2'b00;
            addr0 = 10'(i); addr1 = 10'(16 + i);
            @(negedge clk);
            check("t3_gnt", 32'(gnt), (i % 2 == 0) ? 32'b01 : 32'b10);
            next_cycle();
        end
        idle_inputs();
        repeat (4) next_cycle();
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // P1 locked burst against continuous P0
        apply_reset(2);
        for (int c = 0; c < 20; c++) begin
            req = (c == 0) ? 2'b10 : 2'b11;
            lock = 2'b10; we = 2'b00;
            addr0 = 10'(768 + c); addr1 = 10'(512 + c);
            @(negedge clk);
            check("t4_gnt", 32'(gnt), (c == 16) ? 32'b01 : 32'b10);
            next_cycle();
        end
        idle_inputs();
        repeat (4) next_cycle();
        check("t4_drain", 32'(exp_q.size()), 32'd0);

        // P1 read 0x3FF, reset in the following cycle
        req = 2'b10; we = 2'b00; addr1 = 10'h3FF;
        @(negedge clk);
        check("t5_gnt", 32'(gnt), 32'b10);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t5_pin_a", 32'(sram_a), 32'h3FF);
        check("t5_pin_wen", 32'(sram_wen), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t5_rst_wen", 32'(sram_wen), 32'd1);
        check("t5_rst_a", 32'(sram_a), 32'd0);
        check("t5_rst_d", 32'(sram_d), 32'd0);
        check("t5_rst_rvalid", 32'(rvalid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        next_cycle();
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t5_no_rvalid", 32'(rvalid[1]), 32'd0);
            next_cycle();
        end

        // 1024 P1 reads with random P0 writes near the read stream
        for (int i = 0; i < 1024; i++) begin
            int  tries;
            bit  done;
            tries = 0;
            done  = 1'b0;
            while (!done) begin
                req    = {1'b1, 1'($urandom_range(0, 1))};
                we     = 2'b01;
                lock   = 2'b00;
                addr1  = 10'(i);
                addr0  = 10'(i + int'($urandom_range(0, 3)));
                wdata0 = 8'($urandom_range(0, 255));
                @(negedge clk);
                if (gnt[1]) begin
                    done = 1'b1;
                end else begin
                    tries++;
                    if (tries > 8) begin
                        checks++;
                        errors++;
                        $display("FAIL t6_p1_starved: got no gnt[1] for read %0d expected grant within 8 cycles", i);
                        done = 1'b1;
                    end
                end
                next_cycle();
            end
        end
        idle_inputs();
        repeat (6) next_cycle();
        @(negedge clk);
        check("t6_drain", 32'(exp_q.size()), 32'd0);
        check("t6_busy_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
